// File: rtl/pla_chk_pkg.sv
// Shared types and default sizes for the PLA response checker.
// Contents:
//   N_IN_DEF / N_OUT_DEF - default input-vector and response widths
//   TBL_DEPTH            - expected-table depth for the default input width
//   chk_state_e          - run-control FSM states
package pla_chk_pkg;

    localparam int unsigned N_IN_DEF  = 4;
    localparam int unsigned N_OUT_DEF = 4;
    localparam int unsigned TBL_DEPTH = 2 ** N_IN_DEF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } chk_state_e;

endpackage

// File: rtl/pla_exp_table.sv
// Expected-response register file: one synchronous write port, one combinational
// read port, every entry cleared by asynchronous reset.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   i_we/i_waddr/i_wdata - write strobe, index, data
//   i_raddr / o_rdata   - combinational read
module pla_exp_table
    import pla_chk_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [N_IN-1:0]  i_waddr,
    input  logic [N_OUT-1:0] i_wdata,
    input  logic [N_IN-1:0]  i_raddr,
    output logic [N_OUT-1:0] o_rdata
);

    logic [N_OUT-1:0] r_mem [2**N_IN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**N_IN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pla_resp_checker.sv
// PLA response checker: accepts (vector, response) pairs, compares each response
// with a programmable expected truth table through a 2-stage pipeline and keeps
// saturating pass/fail counts plus a first-failure record.
// Optional feature: define PLA_CHK_COVERAGE_EN to add cov_map / cov_full.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_data    - table write, honoured only in IDLE
//   start                       - begin a run from IDLE or DONE
//   in_valid/in_ready           - pair handshake (in_ready registered, RUN only)
//   in_vec/in_resp              - stimulus vector and observed DUT response
//   busy/done                   - RUN or DRAIN / DONE
//   pass_cnt/fail_cnt           - saturating match / mismatch counts
//   err_sticky, ff_vec/resp/exp - first-failure record
//   cov_map/cov_full            - vectors compared this run (optional)
module pla_resp_checker
    import pla_chk_pkg::*;
#(
    parameter int unsigned N_IN    = N_IN_DEF,
    parameter int unsigned N_OUT   = N_OUT_DEF,
    parameter int unsigned NUM_VEC = 24,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic [N_OUT-1:0] in_resp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic [N_IN-1:0]  ff_vec,
    output logic [N_OUT-1:0] ff_resp,
    output logic [N_OUT-1:0] ff_exp
`ifdef PLA_CHK_COVERAGE_EN
    ,
    output logic [2**N_IN-1:0] cov_map,
    output logic               cov_full
`endif
);

    if (NUM_VEC == 0) begin : g_num_vec_zero
        $error("pla_resp_checker: NUM_VEC must be nonzero");
    end

    localparam int unsigned   AccW    = $clog2(NUM_VEC + 1);
    localparam logic [AccW-1:0] LastAcc = AccW'(NUM_VEC - 1);

    chk_state_e       r_state, w_state_d;
    logic             r_in_ready;
    logic [AccW-1:0]  r_acc_cnt;
    logic             w_start, w_accept, w_last, w_tbl_we;
    logic [N_OUT-1:0] w_tbl_rdata;

    logic             r_s1_valid, r_s2_valid, r_s2_match;
    logic [N_IN-1:0]  r_s1_vec, r_s2_vec;
    logic [N_OUT-1:0] r_s1_resp, r_s1_exp, r_s2_resp, r_s2_exp;

    logic [CNT_W-1:0] r_pass, r_fail;
    logic             r_err;
    logic [N_IN-1:0]  r_ff_vec;
    logic [N_OUT-1:0] r_ff_resp, r_ff_exp;

    assign w_start  = start && (r_state == StIdle || r_state == StDone);
    assign w_accept = in_valid && r_in_ready;
    assign w_last   = w_accept && (r_acc_cnt == LastAcc);
    assign w_tbl_we = cfg_we && (r_state == StIdle);

    pla_exp_table #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_tbl_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (in_vec),
        .o_rdata (w_tbl_rdata)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StDone: if (start) w_state_d = StRun;
            StRun:          if (w_last) w_state_d = StDrain;
            StDrain:        if (!r_s1_valid && !r_s2_valid) w_state_d = StDone;
            default:        w_state_d = StIdle;
        endcase
    end

    // in_ready follows the next state so it drops on the edge of the final accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b0;
            r_acc_cnt  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d == StRun);
            if (w_start) begin
                r_acc_cnt <= '0;
            end else if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + AccW'(1);
            end
        end
    end

    // S1 captures the pair and its expected value; S2 holds the compare result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_vec   <= '0;
            r_s1_resp  <= '0;
            r_s1_exp   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_match <= 1'b0;
            r_s2_vec   <= '0;
            r_s2_resp  <= '0;
            r_s2_exp   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_vec  <= in_vec;
                r_s1_resp <= in_resp;
                r_s1_exp  <= w_tbl_rdata;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_match <= (r_s1_resp == r_s1_exp);
                r_s2_vec   <= r_s1_vec;
                r_s2_resp  <= r_s1_resp;
                r_s2_exp   <= r_s1_exp;
            end
        end
    end

    // Statistics commit as S2 retires, giving results two edges after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass    <= '0;
            r_fail    <= '0;
            r_err     <= 1'b0;
            r_ff_vec  <= '0;
            r_ff_resp <= '0;
            r_ff_exp  <= '0;
        end else if (w_start) begin
            r_pass    <= '0;
            r_fail    <= '0;
            r_err     <= 1'b0;
            r_ff_vec  <= '0;
            r_ff_resp <= '0;
            r_ff_exp  <= '0;
        end else if (r_s2_valid) begin
            if (r_s2_match) begin
                if (r_pass != '1) r_pass <= r_pass + CNT_W'(1);
            end else begin
                if (r_fail != '1) r_fail <= r_fail + CNT_W'(1);
                if (!r_err) begin
                    r_err     <= 1'b1;
                    r_ff_vec  <= r_s2_vec;
                    r_ff_resp <= r_s2_resp;
                    r_ff_exp  <= r_s2_exp;
                end
            end
        end
    end

`ifdef PLA_CHK_COVERAGE_EN
    logic [2**N_IN-1:0] r_cov_map, w_cov_d;
    logic               r_cov_full;

    always_comb begin
        w_cov_d = r_cov_map;
        if (w_start) begin
            w_cov_d = '0;
        end else if (r_s2_valid) begin
            w_cov_d[r_s2_vec] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cov_map  <= '0;
            r_cov_full <= 1'b0;
        end else begin
            r_cov_map  <= w_cov_d;
            r_cov_full <= &w_cov_d;
        end
    end

    assign cov_map  = r_cov_map;
    assign cov_full = r_cov_full;
`endif

    assign in_ready   = r_in_ready;
    assign busy       = (r_state == StRun) || (r_state == StDrain);
    assign done       = (r_state == StDone);
    assign pass_cnt   = r_pass;
    assign fail_cnt   = r_fail;
    assign err_sticky = r_err;
    assign ff_vec     = r_ff_vec;
    assign ff_resp    = r_ff_resp;
    assign ff_exp     = r_ff_exp;

endmodule

// File: tb/tb_pla_resp_checker.sv
// Scoreboard bench for pla_resp_checker. The driver predicts each result from a
// truth-table model and queues it; a monitor retires queue entries two edges after
// every observed accept and compares the live statistics.
module tb_pla_resp_checker;
    import pla_chk_pkg::*;

    localparam int unsigned NV     = 20;
    localparam int unsigned CW     = 4;
    localparam int          CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, cfg_we, start, in_valid;
    logic [3:0]    cfg_addr, cfg_data, in_vec, in_resp;
    logic          in_ready, busy, done, err_sticky;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic [3:0]    ff_vec, ff_resp, ff_exp;
`ifdef PLA_CHK_COVERAGE_EN
    logic [15:0]   cov_map;
    logic          cov_full;
`endif

    pla_resp_checker #(
        .N_IN    (N_IN_DEF),
        .N_OUT   (N_OUT_DEF),
        .NUM_VEC (NV),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .in_resp    (in_resp),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .err_sticky (err_sticky),
        .ff_vec     (ff_vec),
        .ff_resp    (ff_resp),
        .ff_exp     (ff_exp)
`ifdef PLA_CHK_COVERAGE_EN
        ,
        .cov_map    (cov_map),
        .cov_full   (cov_full)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         pass;
        int         fail;
        bit         err;
        logic [3:0] fv, fr, fe;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_tbl [TBL_DEPTH];
    int         m_state;  // 0 idle, 1 run, 2 drain, 3 done
    int         m_acc, m_pass, m_fail;
    bit         m_err;
    logic [3:0] m_fv, m_fr, m_fe;
    logic [15:0] m_cov;

    function automatic logic [3:0] f_ref(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {a & b, b | c, a ^ d, ~c};
    endfunction

    function automatic int sat(input int v);
        return (v > CNTMAX) ? CNTMAX : v;
    endfunction

    task automatic clear_run();
        m_acc = 0; m_pass = 0; m_fail = 0; m_err = 0;
        m_fv = 0; m_fr = 0; m_fe = 0; m_cov = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < TBL_DEPTH; i++) m_tbl[i] = 4'h0;
        clear_run();
        m_state = 0;
    endtask

    task automatic model_accept(input logic [3:0] v, input logic [3:0] r);
        exp_t e;
        m_acc++;
        if (r == m_tbl[v]) m_pass++;
        else begin
            m_fail++;
            if (!m_err) begin
                m_err = 1; m_fv = v; m_fr = r; m_fe = m_tbl[v];
            end
        end
        m_cov[v] = 1'b1;
        e.pass = sat(m_pass); e.fail = sat(m_fail); e.err = m_err;
        e.fv = m_fv; e.fr = m_fr; e.fe = m_fe;
        sb_q.push_back(e);
        if (m_acc == NV) m_state = 2;
    endtask

    // ---------------- monitor ----------------
    bit sh0 = 0, sh1 = 0, sh2 = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sh0 = 0; sh1 = 0; sh2 = 0;
                sb_q.delete();
            end else begin
                if (sh2) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mon_underflow: result seen, expected none queued");
                    end else begin
                        e = sb_q.pop_front();
                        chk("mon_pass_cnt", 32'(pass_cnt), e.pass);
                        chk("mon_fail_cnt", 32'(fail_cnt), e.fail);
                        chk("mon_err_sticky", 32'(err_sticky), 32'(e.err));
                        chk("mon_ff_vec", 32'(ff_vec), 32'(e.fv));
                        chk("mon_ff_resp", 32'(ff_resp), 32'(e.fr));
                        chk("mon_ff_exp", 32'(ff_exp), 32'(e.fe));
                    end
                end
                sh2 = sh1; sh1 = sh0;
                sh0 = in_valid && in_ready;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] d);
        cfg_we = 1; cfg_addr = a; cfg_data = d;
        if (m_state == 0) m_tbl[a] = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic do_start();
        bit take;
        take = (m_state == 0 || m_state == 3);
        start = 1;
        if (take) begin
            clear_run();
            m_state = 1;
        end
        tick();
        start = 0;
        if (m_state == 1) chk("busy_in_run", 32'(busy), 1);
    endtask

    task automatic start_with_write(input logic [3:0] a, input logic [3:0] d);
        cfg_we = 1; cfg_addr = a; cfg_data = d; start = 1;
        if (m_state == 0) m_tbl[a] = d;
        clear_run();
        m_state = 1;
        tick();
        cfg_we = 0; start = 0;
    endtask

    task automatic send(input logic [3:0] v, input logic [3:0] r, input bit val);
        bit exp_rdy, acc;
        exp_rdy = (m_state == 1);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        in_valid = val; in_vec = v; in_resp = r;
        acc = val && exp_rdy;
        tick();
        in_valid = 0;
        if (acc) model_accept(v, r);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 1);
        m_state = 3;
    endtask

    task automatic check_results();
        chk("res_pass_cnt", 32'(pass_cnt), sat(m_pass));
        chk("res_fail_cnt", 32'(fail_cnt), sat(m_fail));
        chk("res_err_sticky", 32'(err_sticky), 32'(m_err));
        chk("res_ff_vec", 32'(ff_vec), 32'(m_fv));
        chk("res_ff_resp", 32'(ff_resp), 32'(m_fr));
        chk("res_ff_exp", 32'(ff_exp), 32'(m_fe));
        chk("res_busy", 32'(busy), 0);
        chk("res_in_ready", 32'(in_ready), 0);
`ifdef PLA_CHK_COVERAGE_EN
        chk("res_cov_map", 32'(cov_map), 32'(m_cov));
        chk("res_cov_full", 32'(cov_full), 32'(&m_cov));
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass_cnt"}, 32'(pass_cnt), 0);
        chk({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
        chk({tag, "_err_sticky"}, 32'(err_sticky), 0);
        chk({tag, "_ff"}, 32'({ff_vec, ff_resp, ff_exp}), 0);
`ifdef PLA_CHK_COVERAGE_EN
        chk({tag, "_cov_map"}, 32'(cov_map), 0);
`endif
    endtask

    function automatic logic [3:0] maybe_bad(input logic [3:0] v, input int pct);
        if ($urandom_range(0, 99) < pct) return 4'($urandom_range(0, 15));
        return m_tbl[v];
    endfunction

    initial begin
        logic [3:0] v;
        int n;
        rst = 1; cfg_we = 0; cfg_addr = 0; cfg_data = 0; start = 0;
        in_valid = 0; in_vec = 0; in_resp = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        tick();

        // Full-coverage run, all correct, back-to-back; pass_cnt saturates.
        for (int a = 0; a < 16; a++) cfg_write(4'(a), f_ref(4'(a)));
        do_start();
        for (int i = 0; i < NV; i++) begin
            v = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
            send(v, m_tbl[v], 1);
        end
        wait_done(10, n);
        chk("done_latency_after_last", 32'(n), 3);
        check_results();

        // Rerun from DONE: first failure at 5th pair, a later mismatch keeps ff_*.
        do_start();
        for (int i = 0; i < NV; i++) begin
            if (i == 4) send(4'b0110, 4'b0000, 1);
            else if (i == 10) send(4'd9, ~m_tbl[9], 1);
            else begin
                v = 4'($urandom_range(0, 15));
                send(v, m_tbl[v], 1);
            end
        end
        wait_done(10, n);
        check_results();

        // Gapped valid, then valid held after the final accept.
        do_start();
        for (int i = 0; i < 2 * NV + 6; i++) begin
            v = 4'($urandom_range(0, 15));
            send(v, maybe_bad(v, 30), (i < 2 * NV) ? (i % 2 == 0) : 1'b1);
        end
        wait_done(10, n);
        check_results();

        // Table writes outside IDLE are dropped.
        cfg_write(4'd3, 4'hF);
        do_start();
        cfg_write(4'd3, 4'hF);
        send(4'd3, f_ref(4'd3), 1);
        send(4'd3, 4'hF, 1);
        for (int i = 2; i < NV; i++) begin
            v = 4'($urandom_range(0, 15));
            send(v, maybe_bad(v, 20), 1);
        end
        wait_done(10, n);
        check_results();

        // Reset with two pairs in flight.
        do_start();
        send(4'd1, f_ref(4'd1), 1);
        send(4'd2, 4'h0, 1);
        rst = 1;
        #1;
        check_zero("midrun_rst");
        repeat (2) tick();
        model_reset();
        rst = 0;
        tick();
        check_zero("post_rst");

        // Write and start together; cleared table otherwise reads 0.
        start_with_write(4'd5, 4'hA);
        send(4'd5, 4'hA, 1);
        for (int i = 1; i < NV; i++) begin
            v = 4'($urandom_range(0, 15));
            send(v, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 1);
        end
        wait_done(10, n);
        check_results();

        // Random runs with idle gaps and stray start pulses while busy.
        for (int r = 0; r < 3; r++) begin
            do_start();
            for (int i = 0; i < 200 && m_state == 1; i++) begin
                if (i == 6) do_start();
                else begin
                    v = 4'($urandom_range(0, 15));
                    send(v, maybe_bad(v, 25), $urandom_range(0, 3) != 0);
                end
            end
            do_start();
            wait_done(10, n);
            check_results();
        end

        repeat (4) tick();
        chk("sb_queue_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
